// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port data memory between the CPU
// data path and a debug/loader port, with bounded locked bursts and 1-cycle read return.
module dmem_arbiter #(
  parameter int unsigned DBITS    = 32,
  parameter int unsigned IDX_BITS = 11,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [IDX_BITS-1:0] cpu_idx,
  input  logic [DBITS-1:0]    cpu_wdata,
  input  logic                cpu_lock,
  output logic                cpu_gnt,
  output logic                cpu_stall,
  output logic                cpu_rvalid,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [IDX_BITS-1:0] dbg_idx,
  input  logic [DBITS-1:0]    dbg_wdata,
  input  logic                dbg_lock,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DBITS-1:0]    rdata,
  output logic                mem_we,
  output logic [IDX_BITS-1:0] mem_idx,
  output logic [DBITS-1:0]    mem_wdata,
  input  logic [DBITS-1:0]    mem_rdata
);

  localparam int unsigned CNT_BITS = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(LOCK_MAX);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  // last_q: 1 = DBG was granted last, 0 = CPU
  logic                last_q, last_d;
  owner_e              owner_q, owner_d;
  logic [CNT_BITS-1:0] lock_cnt_q, lock_cnt_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;

  logic                gnt_cpu, gnt_dbg;
  logic                grant_lock;
  owner_e              grant_port;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q       <= 1'b1;
      owner_q      <= OWN_NONE;
      lock_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  // Grant decision: locked owner hold first, then single requester, then round-robin
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (owner_q == OWN_CPU && cpu_req && lock_cnt_q < CNT_MAX) begin
      gnt_cpu = 1'b1;
    end else if (owner_q == OWN_DBG && dbg_req && lock_cnt_q < CNT_MAX) begin
      gnt_dbg = 1'b1;
    end else if (cpu_req && dbg_req) begin
      gnt_cpu = last_q;
      gnt_dbg = ~last_q;
    end else begin
      gnt_cpu = cpu_req;
      gnt_dbg = dbg_req;
    end
    if (!reset_n) begin
      gnt_cpu = 1'b0;
      gnt_dbg = 1'b0;
    end
  end

  // Next-state: ownership, lock count, round-robin pointer, read-valid pipeline
  always_comb begin
    last_d       = last_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    grant_lock   = gnt_cpu ? cpu_lock : dbg_lock;
    grant_port   = gnt_cpu ? OWN_CPU : OWN_DBG;
    cpu_rvalid_d = gnt_cpu & ~cpu_we;
    dbg_rvalid_d = gnt_dbg & ~dbg_we;
    if (gnt_cpu || gnt_dbg) begin
      last_d = gnt_dbg;
      if (grant_lock) begin
        owner_d = grant_port;
        if (owner_q != grant_port) begin
          lock_cnt_d = CNT_ONE;
        end else if (lock_cnt_q != CNT_MAX) begin
          lock_cnt_d = lock_cnt_q + CNT_ONE;
        end
      end else begin
        owner_d    = OWN_NONE;
        lock_cnt_d = '0;
      end
    end else if ((owner_q == OWN_CPU && !cpu_req) || (owner_q == OWN_DBG && !dbg_req)) begin
      owner_d    = OWN_NONE;
      lock_cnt_d = '0;
    end
  end

  // Outputs: memory steered from the granted port, CPU values when idle
  always_comb begin
    cpu_gnt    = gnt_cpu;
    dbg_gnt    = gnt_dbg;
    cpu_stall  = cpu_req & ~gnt_cpu;
    cpu_rvalid = cpu_rvalid_q;
    dbg_rvalid = dbg_rvalid_q;
    rdata      = mem_rdata;
    mem_we     = gnt_dbg ? dbg_we : (gnt_cpu & cpu_we);
    mem_idx    = cpu_idx;
    mem_wdata  = cpu_wdata;
    if (gnt_dbg) begin
      mem_idx   = dbg_idx;
      mem_wdata = dbg_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a synchronous-read memory model.
module tb_dmem_arbiter;

  localparam int unsigned DBITS    = 32;
  localparam int unsigned IDX_BITS = 11;
  localparam int unsigned LOCK_MAX = 16;

  logic                clk;
  logic                reset_n;
  logic                cpu_req, cpu_we, cpu_lock;
  logic [IDX_BITS-1:0] cpu_idx;
  logic [DBITS-1:0]    cpu_wdata;
  logic                cpu_gnt, cpu_stall, cpu_rvalid;
  logic                dbg_req, dbg_we, dbg_lock;
  logic [IDX_BITS-1:0] dbg_idx;
  logic [DBITS-1:0]    dbg_wdata;
  logic                dbg_gnt, dbg_rvalid;
  logic [DBITS-1:0]    rdata;
  logic                mem_we;
  logic [IDX_BITS-1:0] mem_idx;
  logic [DBITS-1:0]    mem_wdata;
  logic [DBITS-1:0]    mem_rdata;

  logic [DBITS-1:0]    mem [0:(1<<IDX_BITS)-1];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(
    .DBITS(DBITS), .IDX_BITS(IDX_BITS), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_idx(cpu_idx), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_idx(dbg_idx), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, read data registered (old data on same-cycle write)
  always @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
    mem_rdata <= mem[mem_idx];
  end

  task automatic chk(input string tag, input logic [DBITS-1:0] got, input logic [DBITS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
  endtask

  initial begin
    idle_all();
    cpu_idx = '0; cpu_wdata = '0; dbg_idx = '0; dbg_wdata = '0;
    reset_n = 1'b0;
    cpu_req = 1'b1;
    repeat (2) step();

    // Reset state
    @(negedge clk);
    chk("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    chk("rst_cpu_stall",  32'(cpu_stall),  32'd1);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    reset_n = 1'b1;
    cpu_req = 1'b0;
    step();

    // CPU write then read of idx 5
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_idx = 11'd5; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("wr_mem_we",  32'(mem_we),  32'd1);
    chk("wr_mem_idx", 32'(mem_idx), 32'd5);
    step();
    cpu_we = 1'b0;
    @(negedge clk);
    chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_mem_we",  32'(mem_we),  32'd0);
    step();
    cpu_req = 1'b0;
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_rdata",      rdata,           32'hDEADBEEF);
    chk("rd_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

    // DBG preload idx 0..2, then back-to-back reads
    dbg_req = 1'b1; dbg_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dbg_idx = 11'(i); dbg_wdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      chk("pre_dbg_gnt", 32'(dbg_gnt), 32'd1);
      step();
    end
    dbg_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dbg_idx = 11'(i);
      @(negedge clk);
      chk("b2b_dbg_gnt", 32'(dbg_gnt), 32'd1);
      step();
      chk("b2b_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
      chk("b2b_rdata",      rdata,           32'hA000_0000 + 32'(i));
      chk("b2b_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    end
    dbg_req = 1'b0;
    step();
    chk("b2b_dbg_rvalid_end", 32'(dbg_rvalid), 32'd0);

    // Round-robin alternation, last granted was DBG
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_idx = 11'(10 + i); dbg_idx = 11'(20 + i);
      @(negedge clk);
      chk("rr_cpu_gnt",   32'(cpu_gnt),   (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_dbg_gnt",   32'(dbg_gnt),   (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_cpu_stall", 32'(cpu_stall), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
    end

    // Locked DBG burst bounded at LOCK_MAX; one CPU access first so DBG wins the tie
    dbg_req = 1'b0;
    @(negedge clk);
    chk("lk_pre_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    dbg_req = 1'b1; dbg_lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lk_dbg_gnt", 32'(dbg_gnt), (i == 16) ? 32'd0 : 32'd1);
      chk("lk_cpu_gnt", 32'(cpu_gnt), (i == 16) ? 32'd1 : 32'd0);
      step();
    end
    idle_all();
    step();

    // Reset while DBG locked and a read is granted
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_idx = 11'd1;
    @(negedge clk);
    chk("rl_dbg_gnt0", 32'(dbg_gnt), 32'd1);
    step();
    @(negedge clk);
    chk("rl_dbg_gnt1", 32'(dbg_gnt), 32'd1);
    #1;
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    chk("rl_in_dbg_gnt",   32'(dbg_gnt),    32'd0);
    chk("rl_in_cpu_gnt",   32'(cpu_gnt),    32'd0);
    chk("rl_in_cpu_stall", 32'(cpu_stall),  32'd1);
    chk("rl_in_mem_we",    32'(mem_we),     32'd0);
    step();
    chk("rl_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rl_dbg_gnt",    32'(dbg_gnt),    32'd0);

    // Release with simultaneous writes to idx 9: CPU first, then DBG overwrites
    cpu_idx = 11'd9; cpu_wdata = 32'h1111_1111;
    dbg_we = 1'b1; dbg_lock = 1'b0; dbg_idx = 11'd9; dbg_wdata = 32'h2222_2222;
    reset_n = 1'b1;
    @(negedge clk);
    chk("cf_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("cf_dbg_gnt", 32'(dbg_gnt), 32'd0);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("cf_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    @(negedge clk);
    chk("cf_dbg_gnt2",   32'(dbg_gnt),   32'd1);
    chk("cf_mem_we",     32'(mem_we),    32'd1);
    chk("cf_mem_wdata",  mem_wdata,      32'h2222_2222);
    step();
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_req = 1'b1;
    @(negedge clk);
    chk("cf_rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0;
    chk("cf_rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("cf_rd_rdata",  rdata,           32'h2222_2222);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory behind the processor's memory-mapped I/O decode between the CPU data path and a debug/loader port. It arbitrates per cycle with round-robin fairness, supports bounded locked bursts, stalls the losing requester, and returns read data one cycle after grant. It sits between the I/O controller's data-memory outputs and the data-memory controller.

## Interface
- DBITS, 32, data word width
- IDX_BITS, 11, word-index width (2048 words)
- LOCK_MAX, 16, maximum consecutive locked grants to one owner

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write enable (qualified by cpu_req)
- cpu_idx  in  IDX_BITS  CPU word index
- cpu_wdata  in  DBITS  CPU write data
- cpu_lock  in  1  CPU requests to keep ownership after this grant
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU read data valid
- dbg_req, dbg_we, dbg_idx, dbg_wdata, dbg_lock  in  1/1/IDX_BITS/DBITS/1  debug port, same meaning as CPU
- dbg_gnt, dbg_rvalid  out  1  debug grant / read valid
- rdata  out  DBITS  read data, shared; qualify with the appropriate rvalid
- mem_we  out  1  to memory write enable
- mem_idx  out  IDX_BITS  to memory index
- mem_wdata  out  DBITS  to memory write data
- mem_rdata  in  DBITS  from memory, synchronous read, valid the cycle after the index is presented

## Operation
- State: last (CPU/DBG, last granted), owner (NONE/CPU/DBG), lock_cnt (clog2(LOCK_MAX+1) bits), cpu_rvalid_q, dbg_rvalid_q.
- Grant decision is combinational each cycle:
  - Owner hold: if owner≠NONE, the owner's req=1, and lock_cnt<LOCK_MAX, grant the owner.
  - Otherwise, if only one port requests, grant it.
  - Otherwise, if both request, grant the port ≠ last.
  - Otherwise, no grant.
- At most one gnt high per cycle. mem_idx, mem_wdata and mem_we come from the granted port. mem_we = gnt & we.
- With no grant: mem_we=0, mem_idx/mem_wdata = CPU values.
- On a granted cycle, at the clock edge:
  - last ← granted port.
  - If the granted port's lock=1: owner ← port. lock_cnt ← lock_cnt+1 if owner was already this port, else 1.
  - If the granted port's lock=0: owner ← NONE, lock_cnt ← 0.
- If the owner drops req, owner ← NONE and lock_cnt ← 0 at the next edge. Normal arbitration applies in that same cycle.
- When lock_cnt reaches LOCK_MAX, the hold rule fails. Round-robin then applies, so the other port wins if it is requesting.
- A granted read (gnt & ~we) sets that port's rvalid_q for exactly the next cycle. rdata = mem_rdata combinationally.
- A granted write produces no rvalid.
- Back-to-back reads: rvalid pulses every cycle, each paired with the data for the previous cycle's index.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req and state in the same cycle. A write is committed at that edge.
- Read latency is 1 cycle from grant to rvalid/rdata.
- A requester must hold req, we, idx and wdata stable until it sees gnt. A non-granted request is not queued.
- Reset values (asynchronous, while reset_n=0): last=DBG (CPU wins the first tie), owner=NONE, lock_cnt=0, both rvalid=0.
- During reset all gnt=0, cpu_stall=cpu_req, mem_we=0.
- Reset mid-burst or mid-read: ownership is dropped and the pending rvalid is cleared. No rvalid appears after release.
- Releasing a lock on the same cycle the other port requests: the released owner's grant stands for that cycle. The other port wins the next tie.
- Throughput: one access per cycle, no bubble when switching grant.

## Test plan
- After reset, cpu_req=1 write idx=5 data=0xDEADBEEF, then read idx=5 → cpu_gnt=1 both cycles, mem_we=1 on the first, cpu_rvalid=1 with rdata=0xDEADBEEF on the cycle after the read.
- Both ports request continuously without lock for 6 cycles → grants alternate CPU, DBG, CPU, DBG, CPU, DBG. cpu_stall=1 on DBG cycles.
- dbg_lock=1 with continuous dbg_req and cpu_req for 20 cycles, LOCK_MAX=16 → DBG granted 16 consecutive cycles, then CPU granted, then DBG reacquires.
- DBG back-to-back reads of idx 0,1,2 while CPU is idle → dbg_rvalid high for 3 consecutive cycles, one cycle delayed, each with matching data. cpu_rvalid stays 0.
- reset_n low while DBG is locked and a read is granted → next cycle dbg_rvalid=0, all gnt=0. After release, a simultaneous request is granted to CPU first.
- CPU write granted while DBG is stalled on a write to the same idx → memory holds the DBG value after both complete, and the order is confirmed by read-back.
